urx_cfg: RTL and testbench

Parametrised, runtime-configurable UART receiver. It is the successor to the fixed 8N1 receiver.
- Adds configurable data width, parity (none/even/odd), 1 or 2 stop bits, and a full-width runtime baud divisor.
- Reports parity and framing errors and recovers from line breaks.
- Sits between the pad-side serial input and the byte-consuming logic (FIFO or command parser).

---
 rtl/urx_pkg.sv | 26 ++
 rtl/urx_sync.sv | 26 ++
 rtl/urx_cfg.sv | 187 ++++++++++++++++++
 tb/tb_urx_cfg.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urx_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Optional build macro: URX_MAJORITY_VOTE_EN (2-of-3 voting on data/parity/stop samples).
package urx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_CLEANUP,
        ST_BREAK
    } urx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_CLKS_PER_BIT = 4;

    // Mode 2'b11 is treated as "no parity", same as PAR_NONE.
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/urx_sync.sv
// Reset-to-idle (high) multi-flop synchroniser for the asynchronous serial line.
// Optional build macro URX_MAJORITY_VOTE_EN has no effect here.
module urx_sync
    import urx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/urx_cfg.sv
// Runtime-configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits.
// Define URX_MAJORITY_VOTE_EN to decide each data/parity/stop bit by 2-of-3 vote around the centre.
module urx_cfg
    import urx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
    input  logic [1:0]           i_Parity_Mode,
    input  logic                 i_Two_Stop,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy,
    output logic [2:0]           o_State
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    urx_state_e           state_q;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_l_q, div_d;
    logic [DIV_WIDTH-1:0] half;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_acc_q;
    logic                 par_err_q;
    logic                 frame_err_q, frame_err_d;
    logic [1:0]           pmode_q;
    logic                 two_stop_q;
    logic                 rx_dv_q;
    logic [DATA_BITS-1:0] rx_byte_q;
    logic                 par_err_o_q;
    logic                 frame_err_o_q;
    logic                 hit;
    logic                 take;
    logic                 bit_s;

    urx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i (i_Clock),
        .rst_i (i_Reset),
        .d_i   (i_Rx_Serial),
        .q_o   (rx_s)
    );

    assign div_d = (i_Clks_Per_Bit < DIV_WIDTH'(MIN_CLKS_PER_BIT))
                 ? DIV_WIDTH'(MIN_CLKS_PER_BIT) : i_Clks_Per_Bit;
    assign half  = (div_l_q - DIV_WIDTH'(1)) >> 1;
    assign hit   = (cnt_q == div_l_q - DIV_WIDTH'(1));
    // The bit counter free-runs across DATA/PARITY/STOP so bit centres stay one div_l apart.
    assign cnt_d = hit ? '0 : cnt_q + DIV_WIDTH'(1);

`ifdef URX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;
    logic       pend_q;
    logic       in_bit_state;

    assign in_bit_state = (state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            hist_q <= 2'b11;
            pend_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], rx_s};
            pend_q <= hit && in_bit_state;
        end
    end

    // Decision lands one cycle after the centre so samples at centre-1, centre, centre+1 are available.
    assign take  = pend_q;
    assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign take  = hit;
    assign bit_s = rx_s;
`endif

    assign frame_err_d = frame_err_q | ~bit_s;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            div_l_q       <= DIV_WIDTH'(MIN_CLKS_PER_BIT);
            bit_idx_q     <= '0;
            stop_idx_q    <= 1'b0;
            shift_q       <= '0;
            par_acc_q     <= 1'b0;
            par_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            pmode_q       <= PAR_NONE;
            two_stop_q    <= 1'b0;
            rx_dv_q       <= 1'b0;
            rx_byte_q     <= '0;
            par_err_o_q   <= 1'b0;
            frame_err_o_q <= 1'b0;
        end else begin
            rx_dv_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q       <= '0;
                    bit_idx_q   <= '0;
                    stop_idx_q  <= 1'b0;
                    par_acc_q   <= 1'b0;
                    par_err_q   <= 1'b0;
                    frame_err_q <= 1'b0;
                    if (!rx_s) begin
                        div_l_q    <= div_d;
                        pmode_q    <= i_Parity_Mode;
                        two_stop_q <= i_Two_Stop;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == half) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    cnt_q <= cnt_d;
                    if (take) begin
                        shift_q   <= {bit_s, shift_q[DATA_BITS-1:1]};
                        par_acc_q <= par_acc_q ^ bit_s;
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= par_enabled(pmode_q) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    cnt_q <= cnt_d;
                    if (take) begin
                        par_err_q <= (pmode_q == PAR_ODD) ? ~(par_acc_q ^ bit_s) : (par_acc_q ^ bit_s);
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    cnt_q <= cnt_d;
                    if (take) begin
                        if (two_stop_q && !stop_idx_q) begin
                            stop_idx_q  <= 1'b1;
                            frame_err_q <= frame_err_d;
                        end else begin
                            rx_dv_q       <= 1'b1;
                            rx_byte_q     <= shift_q;
                            par_err_o_q   <= par_err_q;
                            frame_err_o_q <= frame_err_d;
                            state_q       <= frame_err_d ? ST_BREAK : ST_CLEANUP;
                        end
                    end
                end
                ST_CLEANUP: begin
                    state_q <= ST_IDLE;
                end
                ST_BREAK: begin
                    // Hold here while the line stays low so a break cannot retrigger a frame.
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Rx_DV      = rx_dv_q;
    assign o_Rx_Byte    = rx_byte_q;
    assign o_Parity_Err = par_err_o_q;
    assign o_Frame_Err  = frame_err_o_q;
    assign o_Busy       = (state_q != ST_IDLE);
    assign o_State      = state_q;

endmodule

// File: tb/tb_urx_cfg.sv
// Bench for urx_cfg: 8-bit/2-stage and 7-bit/3-stage instances, table of frames plus corner sequences.
// Honours URX_MAJORITY_VOTE_EN for the expected DV latency and the bit-centre glitch sequence.
module tb_urx_cfg;

    logic        clk;
    logic        rst;

    logic        rx8, ts8, dv8, pe8, fe8, busy8;
    logic [15:0] div8;
    logic [1:0]  pm8;
    logic [7:0]  byte8;
    logic [2:0]  state8;

    logic        rx7, ts7, dv7, pe7, fe7, busy7;
    logic [15:0] div7;
    logic [1:0]  pm7;
    logic [6:0]  byte7;
    logic [2:0]  state7;

    int errors = 0;
    int checks = 0;

    // Expected frames packed as {parity_err, frame_err, byte}.
    logic [9:0] exp8_q[$];
    logic [8:0] exp7_q[$];
    logic [9:0] e8;
    logic [8:0] e7;

    typedef struct {
        int         div_in;
        int         div_line;
        logic [1:0] pmode;
        logic       two;
        logic [7:0] data;
        logic       flip;
        logic       bad1;
        logic       bad2;
        logic       scramble;
        logic [9:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

`ifdef URX_MAJORITY_VOTE_EN
    localparam int EXP_LAT = 156;
`else
    localparam int EXP_LAT = 155;
`endif

    urx_cfg #(.DATA_BITS(8), .DIV_WIDTH(16), .SYNC_STAGES(2)) dut8 (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_Serial    (rx8),
        .i_Clks_Per_Bit (div8),
        .i_Parity_Mode  (pm8),
        .i_Two_Stop     (ts8),
        .o_Rx_DV        (dv8),
        .o_Rx_Byte      (byte8),
        .o_Parity_Err   (pe8),
        .o_Frame_Err    (fe8),
        .o_Busy         (busy8),
        .o_State        (state8)
    );

    urx_cfg #(.DATA_BITS(7), .DIV_WIDTH(16), .SYNC_STAGES(3)) dut7 (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_Serial    (rx7),
        .i_Clks_Per_Bit (div7),
        .i_Parity_Mode  (pm7),
        .i_Two_Stop     (ts7),
        .o_Rx_DV        (dv7),
        .o_Rx_Byte      (byte7),
        .o_Parity_Err   (pe7),
        .o_Frame_Err    (fe7),
        .o_Busy         (busy7),
        .o_State        (state7)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 8) rx8 = v;
        else rx7 = v;
    endtask

    // Hold one bit for n cycles; optionally invert the line for the single cycle at the bit centre.
    task automatic hold_bit(input int which, input logic v, input int n, input bit glitch);
        drive(which, v);
        if (glitch) begin
            repeat (8) @(posedge clk);
            #1 drive(which, ~v);
            @(posedge clk);
            #1 drive(which, v);
            repeat (n - 9) @(posedge clk);
            #1;
        end else begin
            gap(n);
        end
    endtask

    task automatic tx_frame(input int which, input int n, input int nbits, input logic [8:0] data,
                            input logic [1:0] pmode, input logic flip, input logic two,
                            input logic bad1, input logic bad2, input int glitch_k,
                            input logic scramble, input logic end_high);
        logic p;
        hold_bit(which, 1'b0, n, glitch_k == 0);
        if (scramble) begin
            if (which == 8) begin
                div8 = 16'($urandom_range(4, 60));
                pm8  = 2'($urandom_range(0, 3));
                ts8  = 1'($urandom_range(0, 1));
            end else begin
                div7 = 16'($urandom_range(4, 60));
                pm7  = 2'($urandom_range(0, 3));
                ts7  = 1'($urandom_range(0, 1));
            end
        end
        p = 1'b0;
        for (int j = 0; j < nbits; j++) begin
            p = p ^ data[j];
            hold_bit(which, data[j], n, glitch_k == j + 1);
        end
        if (pmode == 2'b01 || pmode == 2'b10) begin
            if (pmode == 2'b10) p = ~p;
            hold_bit(which, p ^ flip, n, 1'b0);
        end
        hold_bit(which, ~bad1, n, 1'b0);
        if (two) hold_bit(which, ~bad2, n, 1'b0);
        if (end_high) drive(which, 1'b1);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && dv8) begin
            if (exp8_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8_unexpected_dv: got byte 0x%0h pe=%0b fe=%0b, expected no DV", byte8, pe8, fe8);
            end else begin
                e8 = exp8_q.pop_front();
                check("dut8_frame{pe,fe,byte}", {22'd0, pe8, fe8, byte8}, {22'd0, e8});
            end
        end
        if (!rst && dv7) begin
            if (exp7_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut7_unexpected_dv: got byte 0x%0h pe=%0b fe=%0b, expected no DV", byte7, pe7, fe7);
            end else begin
                e7 = exp7_q.pop_front();
                check("dut7_frame{pe,fe,byte}", {23'd0, pe7, fe7, byte7}, {23'd0, e7});
            end
        end
    end

    // ---------------- main test ----------------
    initial begin
        int lat;

        vecs[0] = '{16, 16, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0A5};
        vecs[1] = '{16, 16, 2'b01, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 10'h203};
        vecs[2] = '{16, 16, 2'b01, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 10'h003};
        vecs[3] = '{10, 10, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000};
        vecs[4] = '{10, 10, 2'b10, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 10'h2FF};
        vecs[5] = '{ 3,  4, 2'b00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 10'h03C};
        vecs[6] = '{ 0,  4, 2'b11, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 10'h07E};
        vecs[7] = '{12, 12, 2'b00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 10'h181};
        vecs[8] = '{20, 20, 2'b01, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 10'h2C3};
        vecs[9] = '{16, 16, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};

        rst = 1'b1;
        rx8 = 1'b1; div8 = 16'd16; pm8 = 2'b00; ts8 = 1'b0;
        rx7 = 1'b1; div7 = 16'd8;  pm7 = 2'b10; ts7 = 1'b1;
        gap(3);

        check("reset_dv8", {31'd0, dv8}, 32'd0);
        check("reset_byte8", {24'd0, byte8}, 32'd0);
        check("reset_pe8", {31'd0, pe8}, 32'd0);
        check("reset_fe8", {31'd0, fe8}, 32'd0);
        check("reset_busy8", {31'd0, busy8}, 32'd0);
        check("reset_state8", {29'd0, state8}, 32'd0);
        check("reset_byte7", {25'd0, byte7}, 32'd0);
        check("reset_busy7", {31'd0, busy7}, 32'd0);

        rst = 1'b0;
        gap(4);

        // DV latency from the falling start edge, 8N1 at div 16.
        exp8_q.push_back(10'h0A5);
        fork
            tx_frame(8, 16, 8, 9'h0A5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
            begin
                lat = 0;
                while (!dv8 && lat < 400) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        check("dv_latency_cycles", lat, EXP_LAT);
        gap(48);

        for (int i = 0; i < NV; i++) begin
            div8 = 16'(vecs[i].div_in);
            pm8  = vecs[i].pmode;
            ts8  = vecs[i].two;
            exp8_q.push_back(vecs[i].exp);
            tx_frame(8, vecs[i].div_line, 8, {1'b0, vecs[i].data}, vecs[i].pmode, vecs[i].flip,
                     vecs[i].two, vecs[i].bad1, vecs[i].bad2, -1, vecs[i].scramble, 1'b1);
            gap(3 * vecs[i].div_line);
        end

        // Stop bit low with the line held low for 40 bit times.
        div8 = 16'd16; pm8 = 2'b00; ts8 = 1'b0;
        exp8_q.push_back(10'h155);
        tx_frame(8, 16, 8, 9'h055, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            gap(160);
            check("break_busy_held", {31'd0, busy8}, 32'd1);
        end
        rx8 = 1'b1;
        gap(32);
        check("break_release_busy", {31'd0, busy8}, 32'd0);
        check("break_release_state", {29'd0, state8}, 32'd0);
        exp8_q.push_back(10'h05A);
        tx_frame(8, 16, 8, 9'h05A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        gap(48);

        // 5-cycle low pulse is rejected in START.
        rx8 = 1'b0;
        gap(5);
        rx8 = 1'b1;
        gap(24);
        check("glitch_busy", {31'd0, busy8}, 32'd0);
        check("glitch_state", {29'd0, state8}, 32'd0);
        check("glitch_byte_held", {24'd0, byte8}, 32'h5A);

        // 7 data bits, odd parity, two stop bits, div 8.
        div7 = 16'd8; pm7 = 2'b10; ts7 = 1'b1;
        exp7_q.push_back(9'h03C);
        tx_frame(7, 8, 7, 9'h03C, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        gap(24);
        exp7_q.push_back(9'h0BC);
        tx_frame(7, 8, 7, 9'h03C, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1);
        gap(24);
        pm7 = 2'b01;
        exp7_q.push_back(9'h155);
        tx_frame(7, 8, 7, 9'h055, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        gap(24);

        // Reset in the middle of the data bits of 0xFF.
        div8 = 16'd16; pm8 = 2'b00; ts8 = 1'b0;
        fork
            tx_frame(8, 16, 8, 9'h0FF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
            begin
                gap(60);
                rst = 1'b1;
                #1;
                check("midreset_dv", {31'd0, dv8}, 32'd0);
                check("midreset_byte", {24'd0, byte8}, 32'd0);
                check("midreset_pe", {31'd0, pe8}, 32'd0);
                check("midreset_fe", {31'd0, fe8}, 32'd0);
                check("midreset_busy", {31'd0, busy8}, 32'd0);
                gap(10);
                rst = 1'b0;
            end
        join
        gap(32);
        exp8_q.push_back(10'h081);
        tx_frame(8, 16, 8, 9'h081, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        gap(48);

`ifdef URX_MAJORITY_VOTE_EN
        exp8_q.push_back(10'h081);
        tx_frame(8, 16, 8, 9'h081, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1);
        gap(48);
        exp8_q.push_back(10'h081);
        tx_frame(8, 16, 8, 9'h081, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1);
        gap(48);
`endif

        gap(50);
        check("dut8_expected_drained", exp8_q.size(), 32'd0);
        check("dut7_expected_drained", exp7_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
